// File: rtl/fft_bfly_ctrl.sv
// ----------------------------------------------------------------------------
// fft_bfly_ctrl
//   Radix-2 decimation-in-time FFT sequencer for a 1024-point complex working
//   memory. Each butterfly takes three cycles:
//     READ:  addresses are driven and read data is latched.
//     MUL:   the bottom value is multiplied by the twiddle, and both butterfly
//            results are registered onto the write-data outputs.
//     WRITE: write_en is pulsed for one cycle.
//   The sweep covers 10 stages of 512 butterflies. Input must be stored in
//   bit-reversed order; bin k ends up at address k.
//
// Ports
//   Clk, Reset              clock, synchronous active-high reset
//   Start                   sweep request, honoured only while idle
//   Busy, Done              sweep in progress / one-cycle completion pulse
//   i_top, i_bot            butterfly pair addresses (held READ..WRITE)
//   write_en                one-cycle write strobe during WRITE
//   x_*                     write data (registered)
//   y_*                     read data, combinational from i_top / i_bot
//   tw_addr                 twiddle ROM index, held READ..WRITE
//   tw_re, tw_im            Q2.14 twiddle, valid one cycle after tw_addr
// ----------------------------------------------------------------------------
module fft_bfly_ctrl #(
    parameter int SCALE   = 1,
    parameter int TW_FRAC = 14
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    output logic               Busy,
    output logic               Done,
    output logic [9:0]         i_top,
    output logic [9:0]         i_bot,
    output logic               write_en,
    output logic signed [31:0] x_top_re,
    output logic signed [31:0] x_top_im,
    output logic signed [31:0] x_bot_re,
    output logic signed [31:0] x_bot_im,
    input  logic signed [31:0] y_top_re,
    input  logic signed [31:0] y_top_im,
    input  logic signed [31:0] y_bot_re,
    input  logic signed [31:0] y_bot_im,
    output logic [8:0]         tw_addr,
    input  logic signed [15:0] tw_re,
    input  logic signed [15:0] tw_im
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MUL   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [3:0]         stage_r, stage_s;
    logic [8:0]         bfly_r, bfly_s;
    logic               last_s;

    logic               busy_r, done_r, write_en_r;
    logic [9:0]         i_top_r, i_bot_r;
    logic [8:0]         tw_addr_r;
    logic signed [31:0] a_re_r, a_im_r, bb_re_r, bb_im_r;
    logic signed [31:0] x_top_re_r, x_top_im_r, x_bot_re_r, x_bot_im_r;

    logic signed [47:0] prod_rr_s, prod_ii_s, prod_ri_s, prod_ir_s;
    logic signed [48:0] acc_re_s, acc_im_s;
    logic signed [31:0] p_re_s, p_im_s;
    logic signed [32:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;

    // Pair addresses and twiddle index for butterfly b of stage s,
    // packed as {top, bottom, twiddle}.
    function automatic logic [28:0] bfly_addr(input logic [3:0] s, input logic [8:0] b);
        logic [9:0] half;
        logic [9:0] grp;
        logic [9:0] pos;
        logic [9:0] top;
        logic [8:0] tw;
        half = 10'd1 << s;
        grp  = {1'b0, b} >> s;
        pos  = {1'b0, b} & (half - 10'd1);
        top  = (grp << (s + 4'd1)) | pos;
        tw   = 9'(pos << (4'd9 - s));
        return {top, top + half, tw};
    endfunction

    // Next-state and butterfly/stage counter advance.
    always_comb begin
        state_s = state_r;
        stage_s = stage_r;
        bfly_s  = bfly_r;
        last_s  = (stage_r == 4'd9) && (bfly_r == 9'd511);
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ:  state_s = ST_MUL;
            ST_MUL:   state_s = ST_WRITE;
            ST_WRITE: begin
                if (last_s) begin
                    state_s = ST_IDLE;
                    stage_s = 4'd0;
                    bfly_s  = 9'd0;
                end else begin
                    state_s = ST_READ;
                    bfly_s  = bfly_r + 9'd1;
                    if (bfly_r == 9'd511) begin
                        stage_s = stage_r + 4'd1;
                    end else begin
                        stage_s = stage_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                stage_s = 4'd0;
                bfly_s  = 9'd0;
            end
        endcase
    end

    // Complex twiddle multiply and butterfly sums. Sums are widened by one
    // bit so the post-scale result is exact before truncation to 32 bits.
    always_comb begin
        prod_rr_s = bb_re_r * tw_re;
        prod_ii_s = bb_im_r * tw_im;
        prod_ri_s = bb_re_r * tw_im;
        prod_ir_s = bb_im_r * tw_re;
        acc_re_s  = {prod_rr_s[47], prod_rr_s} - {prod_ii_s[47], prod_ii_s};
        acc_im_s  = {prod_ri_s[47], prod_ri_s} + {prod_ir_s[47], prod_ir_s};
        p_re_s    = 32'(acc_re_s >>> TW_FRAC);
        p_im_s    = 32'(acc_im_s >>> TW_FRAC);
        sum_re_s  = {a_re_r[31], a_re_r} + {p_re_s[31], p_re_s};
        sum_im_s  = {a_im_r[31], a_im_r} + {p_im_s[31], p_im_s};
        dif_re_s  = {a_re_r[31], a_re_r} - {p_re_s[31], p_re_s};
        dif_im_s  = {a_im_r[31], a_im_r} - {p_im_s[31], p_im_s};
    end

    // State, counters, data path registers and all outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            stage_r    <= 4'd0;
            bfly_r     <= 9'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            write_en_r <= 1'b0;
            i_top_r    <= 10'd0;
            i_bot_r    <= 10'd0;
            tw_addr_r  <= 9'd0;
            a_re_r     <= 32'sd0;
            a_im_r     <= 32'sd0;
            bb_re_r    <= 32'sd0;
            bb_im_r    <= 32'sd0;
            x_top_re_r <= 32'sd0;
            x_top_im_r <= 32'sd0;
            x_bot_re_r <= 32'sd0;
            x_bot_im_r <= 32'sd0;
        end else begin
            state_r    <= state_s;
            stage_r    <= stage_s;
            bfly_r     <= bfly_s;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_r == ST_WRITE) && last_s;
            write_en_r <= (state_s == ST_WRITE);
            // Addresses are loaded on entry to READ and then held to WRITE.
            if (state_s == ST_READ) begin
                {i_top_r, i_bot_r, tw_addr_r} <= bfly_addr(stage_s, bfly_s);
            end
            if (state_r == ST_READ) begin
                a_re_r  <= y_top_re;
                a_im_r  <= y_top_im;
                bb_re_r <= y_bot_re;
                bb_im_r <= y_bot_im;
            end
            if (state_r == ST_MUL) begin
                x_top_re_r <= 32'(sum_re_s >>> SCALE);
                x_top_im_r <= 32'(sum_im_s >>> SCALE);
                x_bot_re_r <= 32'(dif_re_s >>> SCALE);
                x_bot_im_r <= 32'(dif_im_s >>> SCALE);
            end
        end
    end

    assign Busy     = busy_r;
    assign Done     = done_r;
    assign write_en = write_en_r;
    assign i_top    = i_top_r;
    assign i_bot    = i_bot_r;
    assign tw_addr  = tw_addr_r;
    assign x_top_re = x_top_re_r;
    assign x_top_im = x_top_im_r;
    assign x_bot_re = x_bot_re_r;
    assign x_bot_im = x_bot_im_r;

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_bfly_ctrl
//   Two engines (SCALE=1 and SCALE=0) run side by side, each with its own
//   working memory and twiddle ROM modelled in the bench. Final memory
//   contents are compared with a loop-based fixed-point FFT model, and the
//   address sequence with a table built from the stage/group/position
//   structure of a radix-2 DIT FFT.
// ----------------------------------------------------------------------------
module tb_fft_bfly_ctrl;

    localparam int NBF = 5120;

    logic Clk = 1'b0;
    logic Reset, Start;

    logic               busy1, done1, we1, busy0, done0, we0;
    logic [9:0]         i_top1, i_bot1, i_top0, i_bot0;
    logic [8:0]         tw_addr1, tw_addr0;
    logic signed [31:0] xtr1, xti1, xbr1, xbi1, xtr0, xti0, xbr0, xbi0;
    logic signed [31:0] ytr1, yti1, ybr1, ybi1, ytr0, yti0, ybr0, ybi0;
    logic signed [15:0] twr1, twi1, twr0, twi0;

    logic signed [31:0] m1_re [1024];
    logic signed [31:0] m1_im [1024];
    logic signed [31:0] m0_re [1024];
    logic signed [31:0] m0_im [1024];
    int in1_re [1024];
    int in1_im [1024];
    int in0_re [1024];
    int in0_im [1024];
    int mdl_re [1024];
    int mdl_im [1024];
    logic signed [15:0] rom_re [512];
    logic signed [15:0] rom_im [512];
    int ea_top [NBF];
    int ea_bot [NBF];
    int ea_tw  [NBF];

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    assign ytr1 = m1_re[i_top1];
    assign yti1 = m1_im[i_top1];
    assign ybr1 = m1_re[i_bot1];
    assign ybi1 = m1_im[i_bot1];
    assign ytr0 = m0_re[i_top0];
    assign yti0 = m0_im[i_top0];
    assign ybr0 = m0_re[i_bot0];
    assign ybi0 = m0_im[i_bot0];

    fft_bfly_ctrl #(.SCALE(1), .TW_FRAC(14)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(busy1), .Done(done1),
        .i_top(i_top1), .i_bot(i_bot1), .write_en(we1),
        .x_top_re(xtr1), .x_top_im(xti1), .x_bot_re(xbr1), .x_bot_im(xbi1),
        .y_top_re(ytr1), .y_top_im(yti1), .y_bot_re(ybr1), .y_bot_im(ybi1),
        .tw_addr(tw_addr1), .tw_re(twr1), .tw_im(twi1)
    );

    fft_bfly_ctrl #(.SCALE(0), .TW_FRAC(14)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(busy0), .Done(done0),
        .i_top(i_top0), .i_bot(i_bot0), .write_en(we0),
        .x_top_re(xtr0), .x_top_im(xti0), .x_bot_re(xbr0), .x_bot_im(xbi0),
        .y_top_re(ytr0), .y_top_im(yti0), .y_bot_re(ybr0), .y_bot_im(ybi0),
        .tw_addr(tw_addr0), .tw_re(twr0), .tw_im(twi0)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: memories take the write seen in the finishing cycle,
    // the ROMs register the twiddle for the address seen in that cycle.
    task automatic tick();
        logic w1, w0;
        logic [9:0] t1, b1, t0, b0;
        logic [8:0] a1, a0;
        logic signed [31:0] v1 [4];
        logic signed [31:0] v0 [4];
        w1 = we1; t1 = i_top1; b1 = i_bot1; a1 = tw_addr1;
        w0 = we0; t0 = i_top0; b0 = i_bot0; a0 = tw_addr0;
        v1[0] = xtr1; v1[1] = xti1; v1[2] = xbr1; v1[3] = xbi1;
        v0[0] = xtr0; v0[1] = xti0; v0[2] = xbr0; v0[3] = xbi0;
        @(posedge Clk);
        #1;
        if (w1 === 1'b1) begin
            m1_re[t1] = v1[0]; m1_im[t1] = v1[1]; m1_re[b1] = v1[2]; m1_im[b1] = v1[3];
        end
        if (w0 === 1'b1) begin
            m0_re[t0] = v0[0]; m0_im[t0] = v0[1]; m0_re[b0] = v0[2]; m0_im[b0] = v0[3];
        end
        twr1 = rom_re[a1]; twi1 = rom_im[a1];
        twr0 = rom_re[a0]; twi0 = rom_im[a0];
    endtask

    task automatic check_reset_outputs();
        check("rst_itop1", i_top1, 0);   check("rst_itop0", i_top0, 0);
        check("rst_ibot1", i_bot1, 0);   check("rst_ibot0", i_bot0, 0);
        check("rst_tw1", tw_addr1, 0);   check("rst_tw0", tw_addr0, 0);
        check("rst_we1", we1, 0);        check("rst_we0", we0, 0);
        check("rst_busy1", busy1, 0);    check("rst_busy0", busy0, 0);
        check("rst_done1", done1, 0);    check("rst_done0", done0, 0);
        check("rst_xtr1", xtr1, 0);      check("rst_xti1", xti1, 0);
        check("rst_xbr1", xbr1, 0);      check("rst_xbi1", xbi1, 0);
        check("rst_xtr0", xtr0, 0);      check("rst_xbi0", xbi0, 0);
    endtask

    // Plain stage/group/position DIT FFT in fixed point on mdl_re/mdl_im.
    task automatic model_fft(input int scale);
        for (int st = 0; st < 10; st++) begin
            int half;
            half = 1 << st;
            for (int g = 0; g < 512 / half; g++) begin
                for (int p = 0; p < half; p++) begin
                    int t, u, k, pr, pi;
                    longint br, bi, wr, wi;
                    t  = 2 * half * g + p;
                    u  = t + half;
                    k  = p * (512 / half);
                    br = mdl_re[u]; bi = mdl_im[u];
                    wr = rom_re[k]; wi = rom_im[k];
                    pr = int'((br * wr - bi * wi) >>> 14);
                    pi = int'((br * wi + bi * wr) >>> 14);
                    mdl_re[u] = int'((longint'(mdl_re[t]) - longint'(pr)) >>> scale);
                    mdl_im[u] = int'((longint'(mdl_im[t]) - longint'(pi)) >>> scale);
                    mdl_re[t] = int'((longint'(mdl_re[t]) + longint'(pr)) >>> scale);
                    mdl_im[t] = int'((longint'(mdl_im[t]) + longint'(pi)) >>> scale);
                end
            end
        end
    endtask

    // Compare both engine memories with the model applied to saved inputs.
    task automatic compare_with_model(input bit do1, input bit do0);
        if (do1) begin
            mdl_re = in1_re; mdl_im = in1_im;
            model_fft(1);
            for (int k = 0; k < 1024; k++) begin
                check("s1_bin_re", m1_re[k], mdl_re[k]);
                check("s1_bin_im", m1_im[k], mdl_im[k]);
            end
        end
        if (do0) begin
            mdl_re = in0_re; mdl_im = in0_im;
            model_fft(0);
            for (int k = 0; k < 1024; k++) begin
                check("s0_bin_re", m0_re[k], mdl_re[k]);
                check("s0_bin_im", m0_im[k], mdl_im[k]);
            end
        end
    endtask

    task automatic load_memories();
        for (int k = 0; k < 1024; k++) begin
            m1_re[k] = in1_re[k]; m1_im[k] = in1_im[k];
            m0_re[k] = in0_re[k]; m0_im[k] = in0_im[k];
        end
    endtask

    function automatic int rnd20();
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    // One full sweep from Start (edge 0) to the Done cycle 15361.
    task automatic run_sweep(input bit hold, input bit poke);
        int n;
        n = 0;
        Start = 1'b1;
        tick();
        for (int c = 1; c <= 15361; c++) begin
            if (poke && c >= 600 && c < 620) Start = 1'b1;
            else if (!hold) Start = 1'b0;
            if (we1 === 1'b1) begin
                if (n < NBF) begin
                    check("addr_top1", i_top1, ea_top[n]);
                    check("addr_bot1", i_bot1, ea_bot[n]);
                    check("addr_tw1", tw_addr1, ea_tw[n]);
                    check("addr_top0", i_top0, ea_top[n]);
                    check("addr_tw0", tw_addr0, ea_tw[n]);
                    check("write_cycle", c, 3 + 3 * n);
                end else begin
                    check("extra_write", n, NBF - 1);
                end
                n++;
            end
            if (c == 15360) begin
                check("last_we1", we1, 1);
                check("last_busy1", busy1, 1);
                check("last_done1", done1, 0);
            end
            if (c == 15361) begin
                check("done1", done1, 1);
                check("done0", done0, 1);
                check("busy_off1", busy1, 0);
                check("we_off1", we1, 0);
            end
            if (c < 15361) tick();
        end
        check("write_count", n, NBF);
    endtask

    initial begin
        int n;
        n = 0;
        for (int st = 0; st < 10; st++) begin
            for (int g = 0; g < (512 >> st); g++) begin
                for (int p = 0; p < (1 << st); p++) begin
                    ea_top[n] = (2 << st) * g + p;
                    ea_bot[n] = ea_top[n] + (1 << st);
                    ea_tw[n]  = p << (9 - st);
                    n++;
                end
            end
        end
        for (int k = 0; k < 512; k++) begin
            real ang, cr, ci;
            ang = 2.0 * 3.14159265358979323846 * k / 1024.0;
            cr  = $cos(ang) * 16384.0;
            ci  = -$sin(ang) * 16384.0;
            rom_re[k] = 16'((cr >= 0.0) ? $rtoi(cr + 0.5) : -$rtoi(-cr + 0.5));
            rom_im[k] = 16'((ci >= 0.0) ? $rtoi(ci + 0.5) : -$rtoi(-ci + 0.5));
        end
        for (int k = 0; k < 1024; k++) begin
            in1_re[k] = 0; in1_im[k] = 0; in0_re[k] = 0; in0_im[k] = 0;
        end
        load_memories();
        twr1 = 16'sd0; twi1 = 16'sd0; twr0 = 16'sd0; twi0 = 16'sd0;

        // Power-on reset.
        Start = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        check_reset_outputs();
        Reset = 1'b0;

        // Twiddle corner at k=256, then reset in the middle of the sweep.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 1544; c++) begin
            if (c == 1540) begin
                m1_re[1] = 0; m1_im[1] = 0; m1_re[3] = 100; m1_im[3] = 0;
                m0_re[1] = 0; m0_im[1] = 0; m0_re[3] = 100; m0_im[3] = 0;
            end
            if (c == 1542) begin
                check("corner_we", we1, 1);
                check("corner_top", i_top1, 1);
                check("corner_bot", i_bot1, 3);
                check("corner_tw", tw_addr1, 256);
                check("corner_s1_xtr", xtr1, 0);
                check("corner_s1_xti", xti1, -50);
                check("corner_s1_xbr", xbr1, 0);
                check("corner_s1_xbi", xbi1, 50);
                check("corner_s0_xti", xti0, -100);
                check("corner_s0_xbi", xbi0, 100);
            end
            if (c < 1544) tick();
        end
        Reset = 1'b1;
        tick();
        check_reset_outputs();
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("post_rst_we1", we1, 0);
            check("post_rst_busy1", busy1, 0);
            check("post_rst_we0", we0, 0);
        end

        // Impulses, with Start pulsed while busy.
        for (int k = 0; k < 1024; k++) begin
            in1_re[k] = 0; in1_im[k] = 0; in0_re[k] = 0; in0_im[k] = 0;
        end
        in1_re[0] = 1048576;
        in0_re[0] = 1000;
        load_memories();
        run_sweep(1'b0, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            check("imp1_re", m1_re[k], 1024);
            check("imp1_im", m1_im[k], 0);
            check("imp0_re", m0_re[k], 1000);
            check("imp0_im", m0_im[k], 0);
        end
        tick();
        check("idle_after_done", busy1, 0);

        // DC on SCALE=1, random data on SCALE=0.
        for (int k = 0; k < 1024; k++) begin
            in1_re[k] = 1024; in1_im[k] = 0;
            in0_re[k] = rnd20(); in0_im[k] = rnd20();
        end
        load_memories();
        run_sweep(1'b0, 1'b0);
        check("dc_bin0_re", m1_re[0], 1024);
        check("dc_bin0_im", m1_im[0], 0);
        for (int k = 1; k < 1024; k++) begin
            check("dc_small_re", (m1_re[k] >= -10 && m1_re[k] <= 10) ? 1 : 0, 1);
            check("dc_small_im", (m1_im[k] >= -10 && m1_im[k] <= 10) ? 1 : 0, 1);
        end
        compare_with_model(1'b1, 1'b1);
        tick();

        // Random data on both, Start held high through Done.
        for (int k = 0; k < 1024; k++) begin
            in1_re[k] = rnd20(); in1_im[k] = rnd20();
            in0_re[k] = rnd20() >>> 4; in0_im[k] = rnd20() >>> 4;
        end
        load_memories();
        run_sweep(1'b1, 1'b0);
        compare_with_model(1'b1, 1'b1);
        tick();
        check("restart_busy1", busy1, 1);
        check("restart_top1", i_top1, 0);
        check("restart_bot1", i_bot1, 1);
        check("restart_busy0", busy0, 1);
        Start = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check("final_busy1", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
